sysid_check_master: RTL and testbench
=====================================

Name: sysid_check_master

Overview:
- Avalon-MM read initiator that interrogates the system-ID responder. The responder returns the ID at word 0 and the build timestamp at word 1.
- Issues two reads (word 0, then word 1), honours waitrequest and a fixed read latency, and compares both words against expected constants.
- Reports pass/fail/timeout to a status LED or host register.
- Sits beside the Nios II master on the same interconnect. Used as a boot-time bitstream sanity check.

Parameters:
- EXP_ID, 32'h0000_0000, expected word 0
- EXP_TIMESTAMP, 32'd1476641584, expected word 1
- READ_LATENCY, 0, cycles from accepted read to readdata sample (0..3)
- TIMEOUT_CYCLES, 255, max cycles per access before abort (>=1)
- AUTO_START, 1, start one check on the first cycle after reset

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a check when idle
- avm_address  out  1  word address to responder
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  responder stall
- avm_readdata  in  32  responder data
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at completion
- pass  out  1  sticky result: both words matched
- timeout  out  1  sticky: an access exceeded TIMEOUT_CYCLES
- id_value  out  32  captured word 0
- ts_value  out  32  captured word 1

Behaviour:
- Reset, one clock, synchronous, active-high. All outputs go to 0; state goes to IDLE. If AUTO_START=1, a pending-start flag is set so the check starts on the first cycle after reset deasserts.
- Reset asserted mid-access aborts immediately. avm_read drops in that same cycle's registered output. No done pulse is generated.
- States:
  - IDLE: avm_read=0, busy=0. Moves to RD_ID on start or pending flag, which then clears. The transition clears pass, timeout, id_value and ts_value.
  - RD_ID: avm_read=1, avm_address=0; address and read are held stable while waitrequest=1. When waitrequest=0, the read is accepted. With READ_LATENCY=0, readdata is captured that cycle into id_value and the state goes to RD_TS. Otherwise the state goes to LAT_ID with avm_read=0.
  - LAT_ID: counts READ_LATENCY-1 cycles, captures readdata on the final count, then goes to RD_TS.
  - RD_TS / LAT_TS: identical to RD_ID / LAT_ID with avm_address=1, capturing into ts_value. On capture the state goes to FIN.
  - FIN: pass = (id_value==EXP_ID) && (ts_value==EXP_TIMESTAMP); done=1 for exactly one cycle; then IDLE.
- Timing: with no stalls and READ_LATENCY=0, there are exactly 2 cycles of avm_read (word 0 then word 1). done fires 3 cycles after leaving IDLE.
- Timeout:
  - An 8-bit-minimum counter, sized by $clog2(TIMEOUT_CYCLES+1), resets on entry to each RD_* state and increments while waitrequest=1.
  - When it reaches TIMEOUT_CYCLES: avm_read drops, timeout=1, pass=0, and the state goes to FIN with no compare (pass forced to 0).
  - Latency states do not time out.
- start while busy is ignored (not queued). start in the same cycle as done/FIN is also ignored.
- busy=1 in every state except IDLE.
- pass, timeout, id_value and ts_value hold until the next check begins or reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package sysid_pkg:
  - state enum {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN}
  - word address constants SYSID_ADDR_ID=0, SYSID_ADDR_TS=1
  - default EXP_TIMESTAMP constant
- One natural sub-module: avm_single_read. It performs one read with waitrequest/latency/timeout handling and returns data_valid and timed_out. The top level sequences two instances' worth of requests through it, or reuses one instance.

Test Plan:
- Zero-wait responder, word0=0, word1=1476641584, AUTO_START=1, reset released -> avm_read high for 2 cycles at address 0 then 1; done pulse on cycle 3; pass=1; ts_value=1476641584.
- Responder word1=1476641585 -> done pulse; pass=0; ts_value=1476641585; timeout=0.
- waitrequest held high 4 cycles on address 0 -> address/read stable for all 4 cycles; capture on cycle 5; pass=1; done 4 cycles later than the zero-wait case.
- READ_LATENCY=2, zero-wait responder -> avm_read low during the latency cycles; data sampled 2 cycles after acceptance; pass=1.
- TIMEOUT_CYCLES=8, waitrequest stuck high -> after 8 stall cycles avm_read=0, timeout=1, pass=0, done pulse; a following start with a healthy responder -> timeout cleared, pass=1.
- reset asserted during RD_TS -> next cycle avm_read=0, busy=0, no done pulse; start pulse during busy -> ignored, exactly one done pulse.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot check.
package sysid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      LAT_ID,
      RD_TS,
      LAT_TS,
      FIN
   } sysid_state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [31:0] SYSID_DEFAULT_ID        = 32'h0000_0000;
   localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1476641584;

   // Stall counter width: wide enough for TIMEOUT_CYCLES, never narrower than 8 bits.
   function automatic int tmo_width(input int cycles);
      int w;
      w = $clog2(cycles + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read-only bus between the check master and the system-ID responder.
// Handshake: avm_read is the request valid and !avm_waitrequest is the ready; a
// read transfers in the cycle where avm_read=1 and avm_waitrequest=0. While
// stalled the master holds avm_read and avm_address stable. readdata is sampled
// READ_LATENCY cycles after the transfer cycle (same cycle when 0).
interface sysid_check_master_if;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata
   );
endinterface

// File: rtl/sysid_check_master_avm_single_read.sv
// One Avalon-MM read: acceptance, fixed-latency data strobe and per-access stall timeout.
module avm_single_read
   import sysid_pkg::*;
#(
   parameter int READ_LATENCY   = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic rd_active,    // read strobe is asserted this cycle
   input  logic lat_active,   // waiting out the read latency this cycle
   input  logic waitrequest,
   output logic accepted,
   output logic data_valid,   // readdata is to be captured this cycle
   output logic timed_out
);

   localparam int            CW       = tmo_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]    LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

   logic [CW-1:0] tmo_cnt;
   logic [1:0]    lat_cnt;

   assign accepted   = rd_active && !waitrequest;
   assign timed_out  = rd_active && waitrequest && (tmo_cnt == TMO_LAST);
   assign data_valid = (READ_LATENCY == 0) ? accepted
                                           : (lat_active && (lat_cnt == LAT_LAST));

   // Stall counter: held at zero outside a request phase, so each RD phase starts from 0.
   always_ff @(posedge clock) begin
      if (reset || !rd_active || accepted) tmo_cnt <= '0;
      else if (waitrequest)                tmo_cnt <= tmo_cnt + CW'(1);
   end

   // Latency counter: runs only while waiting for readdata; latency phases never time out.
   always_ff @(posedge clock) begin
      if (reset || !lat_active) lat_cnt <= 2'd0;
      else                      lat_cnt <= lat_cnt + 2'd1;
   end

endmodule

// File: rtl/sysid_check_master.sv
// Boot-time bitstream sanity check: reads system-ID words 0 and 1 and compares them.
module sysid_check_master
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXP_ID         = SYSID_DEFAULT_ID,
   parameter logic [31:0] EXP_TIMESTAMP  = SYSID_DEFAULT_TIMESTAMP,
   parameter int          READ_LATENCY   = 0,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   sysid_check_master_if.master  avm,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [31:0]           id_value,
   output logic [31:0]           ts_value,
   output sysid_state_t          state_dbg
);

   sysid_state_t state, next_state;
   logic         pending;
   logic         in_rd, in_lat, in_id_phase, in_ts_phase;
   logic         accepted, data_valid, timed_out;

   logic         read_d, address_d, busy_d, done_d, pass_d, timeout_d, pending_d;
   logic [31:0]  id_d, ts_d;

   assign in_rd       = (state == RD_ID)  || (state == RD_TS);
   assign in_lat      = (state == LAT_ID) || (state == LAT_TS);
   assign in_id_phase = (state == RD_ID)  || (state == LAT_ID);
   assign in_ts_phase = (state == RD_TS)  || (state == LAT_TS);
   assign state_dbg   = state;

   avm_single_read #(
      .READ_LATENCY   (READ_LATENCY),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_read (
      .clock       (clock),
      .reset       (reset),
      .rd_active   (in_rd),
      .lat_active  (in_lat),
      .waitrequest (avm.avm_waitrequest),
      .accepted    (accepted),
      .data_valid  (data_valid),
      .timed_out   (timed_out)
   );

   // State and registered outputs; reset aborts any access and re-arms auto start.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         pending         <= AUTO_START;
         avm.avm_read    <= 1'b0;
         avm.avm_address <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         timeout         <= 1'b0;
         id_value        <= 32'h0;
         ts_value        <= 32'h0;
      end else begin
         state           <= next_state;
         pending         <= pending_d;
         avm.avm_read    <= read_d;
         avm.avm_address <= address_d;
         busy            <= busy_d;
         done            <= done_d;
         pass            <= pass_d;
         timeout         <= timeout_d;
         id_value        <= id_d;
         ts_value        <= ts_d;
      end
   end

   // Sequencing: word 0, optional latency, word 1, optional latency, report.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:   if (start || pending) next_state = RD_ID;
         RD_ID:  if (timed_out)        next_state = FIN;
                 else if (accepted)    next_state = (READ_LATENCY == 0) ? RD_TS : LAT_ID;
         LAT_ID: if (data_valid)       next_state = RD_TS;
         RD_TS:  if (timed_out)        next_state = FIN;
                 else if (accepted)    next_state = (READ_LATENCY == 0) ? FIN : LAT_TS;
         LAT_TS: if (data_valid)       next_state = FIN;
         FIN:                          next_state = IDLE;
         default:                      next_state = IDLE;
      endcase
   end

   // Next values of the registered outputs, derived from the upcoming state and capture events.
   always_comb begin
      read_d    = (next_state == RD_ID) || (next_state == RD_TS);
      address_d = ((next_state == RD_TS) || (next_state == LAT_TS)) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy_d    = (next_state != IDLE);
      done_d    = (next_state == FIN);
      pending_d = pending;
      pass_d    = pass;
      timeout_d = timeout;
      id_d      = id_value;
      ts_d      = ts_value;
      if ((state == IDLE) && (next_state == RD_ID)) begin
         pending_d = 1'b0;
         pass_d    = 1'b0;
         timeout_d = 1'b0;
         id_d      = 32'h0;
         ts_d      = 32'h0;
      end
      if (data_valid && in_id_phase) id_d = avm.avm_readdata;
      if (data_valid && in_ts_phase) begin
         ts_d   = avm.avm_readdata;
         pass_d = (id_value == EXP_ID) && (avm.avm_readdata == EXP_TIMESTAMP);
      end
      if (timed_out) begin
         timeout_d = 1'b1;
         pass_d    = 1'b0;
      end
   end

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: two configurations, directed scenarios, then random checks.
module tb_sysid_check_master;
   import sysid_pkg::*;

   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'd1476641584;
   localparam int LAT0   = 0;
   localparam int TMO0   = 255;
   localparam int LAT1   = 2;
   localparam int TMO1   = 8;
   localparam int BUDGET = 400;

   int checks   = 0;
   int failures = 0;

   // Clock and reset
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset0, reset1, start0, start1;
   wire  [1:0]   busy_v, done_v, pass_v, timeout_v;
   wire  [31:0]  id0, id1, ts0, ts1;
   sysid_state_t st0, st1;

   sysid_check_master_if bus0 ();
   sysid_check_master_if bus1 ();

   wire [1:0] rd_v   = {bus1.avm_read, bus0.avm_read};
   wire [1:0] addr_v = {bus1.avm_address, bus0.avm_address};

   sysid_check_master #(
      .EXP_ID(EXP_ID), .EXP_TIMESTAMP(EXP_TS), .READ_LATENCY(LAT0),
      .TIMEOUT_CYCLES(TMO0), .AUTO_START(1'b1)
   ) dut0 (
      .clock(clock), .reset(reset0), .start(start0), .avm(bus0),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .timeout(timeout_v[0]),
      .id_value(id0), .ts_value(ts0), .state_dbg(st0)
   );

   sysid_check_master #(
      .EXP_ID(EXP_ID), .EXP_TIMESTAMP(EXP_TS), .READ_LATENCY(LAT1),
      .TIMEOUT_CYCLES(TMO1), .AUTO_START(1'b0)
   ) dut1 (
      .clock(clock), .reset(reset1), .start(start1), .avm(bus1),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .timeout(timeout_v[1]),
      .id_value(id1), .ts_value(ts1), .state_dbg(st1)
   );

   // Responder model: per-address stall plan, memory words, fixed-latency data return
   int          plan_stall [2][2];
   int          stalled    [2][2];
   logic [31:0] mem        [2][2];
   int          pend_cnt   [2];
   logic [31:0] pend_data  [2];

   task automatic respond(input int i, input int lat, input logic rd, input logic addr,
                          output logic wr, output logic [31:0] rdata);
      int a;
      a     = addr ? 1 : 0;
      rdata = $urandom();
      if (rd) wr = (stalled[i][a] < plan_stall[i][a]);
      else    wr = 1'($urandom_range(0, 1));
      if (rd && wr) stalled[i][a]++;
      if (pend_cnt[i] > 0) begin
         pend_cnt[i]--;
         if (pend_cnt[i] == 0) rdata = pend_data[i];
      end
      if (rd && !wr) begin
         if (lat == 0) rdata = mem[i][a];
         else begin
            pend_cnt[i]  = lat;
            pend_data[i] = mem[i][a];
         end
      end
   endtask

   logic        wr0, wr1;
   logic [31:0] rdat0, rdat1;

   always @(negedge clock) begin
      respond(0, LAT0, bus0.avm_read, bus0.avm_address, wr0, rdat0);
      bus0.avm_waitrequest = wr0;
      bus0.avm_readdata    = rdat0;
   end

   always @(negedge clock) begin
      respond(1, LAT1, bus1.avm_read, bus1.avm_address, wr1, rdat1);
      bus1.avm_waitrequest = wr1;
      bus1.avm_readdata    = rdat1;
   end

   // Driver tasks
   task automatic arm(input int i, input int s0, input int s1,
                      input logic [31:0] w0, input logic [31:0] w1);
      plan_stall[i][0] = s0;
      plan_stall[i][1] = s1;
      mem[i][0]        = w0;
      mem[i][1]        = w1;
      stalled[i][0]    = 0;
      stalled[i][1]    = 0;
      pend_cnt[i]      = 0;
   endtask

   task automatic set_start(input int i, input logic v);
      if (i == 0) start0 = v;
      else        start1 = v;
   endtask

   task automatic pulse_start(input int i);
      @(negedge clock);
      set_start(i, 1'b1);
      @(negedge clock);
      set_start(i, 1'b0);
   endtask

   function automatic logic [31:0] pick_word(input logic [31:0] good);
      return ($urandom_range(0, 2) == 0) ? $urandom() : good;
   endfunction

   // Scoreboard comparison
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Watches one check from its first busy cycle (caller is at that negedge) through done.
   task automatic run_check(input int i, input string tag, input bit poke);
      int lat, tmo, s0, s1, n0, n1, order_bad, busy_bad, done_at, extra;
      int exp_n0, exp_n1, exp_done;
      bit to0, to1, seen_ts, exp_pass;
      logic [31:0] exp_id, exp_ts;
      lat      = (i == 0) ? LAT0 : LAT1;
      tmo      = (i == 0) ? TMO0 : TMO1;
      s0       = plan_stall[i][0];
      s1       = plan_stall[i][1];
      to0      = (s0 >= tmo);
      to1      = !to0 && (s1 >= tmo);
      exp_n0   = to0 ? tmo : s0 + 1;
      exp_n1   = to0 ? 0 : (to1 ? tmo : s1 + 1);
      exp_done = exp_n0 + (to0 ? 0 : lat) + exp_n1 + ((to0 || to1) ? 0 : lat) + 1;
      exp_pass = !to0 && !to1 && (mem[i][0] == EXP_ID) && (mem[i][1] == EXP_TS);
      exp_id   = to0 ? 32'h0 : mem[i][0];
      exp_ts   = (to0 || to1) ? 32'h0 : mem[i][1];
      n0 = 0; n1 = 0; order_bad = 0; busy_bad = 0; done_at = 0; seen_ts = 0;
      for (int c = 1; c <= BUDGET; c++) begin
         if (rd_v[i]) begin
            if (addr_v[i]) begin n1++; seen_ts = 1; end
            else begin n0++; if (seen_ts) order_bad++; end
         end
         if (!busy_v[i]) busy_bad++;
         if (done_v[i]) begin
            done_at = c;
            set_start(i, poke);
            break;
         end
         if (poke) set_start(i, 1'($urandom_range(0, 1)));
         @(negedge clock);
      end
      check({tag, "_done_cycle"}, done_at, exp_done);
      check({tag, "_reads_w0"}, n0, exp_n0);
      check({tag, "_reads_w1"}, n1, exp_n1);
      check({tag, "_addr_order"}, order_bad, 0);
      check({tag, "_busy_gaps"}, busy_bad, 0);
      @(negedge clock);
      set_start(i, 1'b0);
      check({tag, "_done_width"}, 32'(done_v[i]), 32'(0));
      check({tag, "_idle_busy"}, 32'(busy_v[i]), 32'(0));
      check({tag, "_pass"}, 32'(pass_v[i]), 32'(exp_pass));
      check({tag, "_timeout"}, 32'(timeout_v[i]), 32'(to0 || to1));
      check({tag, "_id"}, (i == 0) ? id0 : id1, exp_id);
      check({tag, "_ts"}, (i == 0) ? ts0 : ts1, exp_ts);
      extra = 0;
      repeat (3) begin
         @(negedge clock);
         if (done_v[i] || busy_v[i]) extra++;
      end
      check({tag, "_no_restart"}, extra, 0);
   endtask

   initial begin
      int found, abort_bad;
      reset0 = 1'b1; reset1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
      arm(0, 0, 0, EXP_ID, EXP_TS);
      arm(1, 0, 0, EXP_ID, EXP_TS);
      repeat (3) @(negedge clock);

      // Reset state
      check("rst_busy", 32'(busy_v), 32'(0));
      check("rst_done", 32'(done_v), 32'(0));
      check("rst_pass", 32'(pass_v), 32'(0));
      check("rst_timeout", 32'(timeout_v), 32'(0));
      check("rst_read", 32'(rd_v), 32'(0));
      check("rst_id", id0, 32'h0);
      check("rst_ts", ts1, 32'h0);
      check("rst_state", 32'(st1), 32'(IDLE));

      // Auto start right after reset, zero-wait responder
      reset0 = 1'b0; reset1 = 1'b0;
      @(negedge clock);
      run_check(0, "auto", 1'b0);
      check("no_auto_dut1", 32'(busy_v[1]), 32'(0));

      // Wrong timestamp word
      arm(0, 0, 0, EXP_ID, EXP_TS + 32'd1);
      pulse_start(0);
      run_check(0, "bad_ts", 1'b0);

      // Four stall cycles on word 0
      arm(0, 4, 0, EXP_ID, EXP_TS);
      pulse_start(0);
      run_check(0, "stall4", 1'b0);

      // Read latency 2, zero-wait responder
      arm(1, 0, 0, EXP_ID, EXP_TS);
      pulse_start(1);
      run_check(1, "lat2", 1'b0);

      // Stuck responder times out, then recovers
      arm(1, 1000, 0, EXP_ID, EXP_TS);
      pulse_start(1);
      run_check(1, "stuck", 1'b0);
      arm(1, 0, 0, EXP_ID, EXP_TS);
      pulse_start(1);
      run_check(1, "recover", 1'b0);

      // Reset while word 1 is being read
      arm(1, 0, 20, EXP_ID, EXP_TS);
      pulse_start(1);
      found = 0;
      for (int c = 0; c < 50; c++) begin
         if (rd_v[1] && addr_v[1]) begin found = 1; break; end
         @(negedge clock);
      end
      check("abort_reached_ts", found, 1);
      reset1 = 1'b1;
      @(negedge clock);
      reset1 = 1'b0;
      check("abort_read", 32'(rd_v[1]), 32'(0));
      check("abort_busy", 32'(busy_v[1]), 32'(0));
      check("abort_done", 32'(done_v[1]), 32'(0));
      abort_bad = 0;
      repeat (12) begin
         @(negedge clock);
         if (done_v[1] || busy_v[1] || rd_v[1]) abort_bad++;
      end
      check("abort_quiet", abort_bad, 0);

      // Start pulses during busy and on done are ignored
      arm(1, 0, 0, EXP_ID, EXP_TS);
      pulse_start(1);
      run_check(1, "poke", 1'b1);

      // Random checks on both configurations
      for (int n = 0; n < 10; n++) begin
         arm(0, $urandom_range(0, 5), $urandom_range(0, 5), pick_word(EXP_ID), pick_word(EXP_TS));
         pulse_start(0);
         run_check(0, $sformatf("rand0_%0d", n), 1'b1);
      end
      for (int n = 0; n < 10; n++) begin
         arm(1, $urandom_range(0, 11), $urandom_range(0, 11), pick_word(EXP_ID), pick_word(EXP_TS));
         pulse_start(1);
         run_check(1, $sformatf("rand1_%0d", n), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
